// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
// Shared constants and helpers for the ripple-carry adder family.
//   FA_DEFAULT_WIDTH : width used by the single-bit exercise instance
//   FA_MAX_WIDTH     : widest operand the adder is meant to be built for
//   fa_width_ok()    : elaboration-time legality test for the WIDTH parameter
// -----------------------------------------------------------------------------
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;
    localparam int FA_MAX_WIDTH     = 64;

    // True when a requested operand width is within the supported range.
    function automatic bit fa_width_ok(input int width);
        return (width >= 1) && (width <= FA_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// One-bit combinational full adder; the building block of the ripple chain.
// Ports:
//   a, b  (in)  : operand bits
//   cin   (in)  : carry from the next-lower bit
//   s     (out) : a ^ b ^ cin
//   cout  (out) : majority(a, b, cin), carry into the next-higher bit
// -----------------------------------------------------------------------------
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/activity_3_full_adder.sv
// -----------------------------------------------------------------------------
// activity_3_full_adder
// Parameterizable ripple-carry adder: {cout, sum} = a + b + c at WIDTH+1 bits.
// The carry ripples through WIDTH full_adder_cell instances (no lookahead).
//
// Parameters:
//   WIDTH : operand/sum width, 1..64 (default 1 = classic 1-bit full adder)
// Ports (declaration order fixed so 5-port positional hookup still works):
//   a    (in,  WIDTH) : operand A, unsigned
//   b    (in,  WIDTH) : operand B, unsigned
//   c    (in,  1)     : carry-in, weight 2^0
//   cout (out, 1)     : carry-out, weight 2^WIDTH
//   sum  (out, WIDTH) : low WIDTH bits of a + b + c
//   clk  (in,  1)     : rising-edge clock, output register only
//   rst  (in,  1)     : asynchronous active-high reset, output register only
//
// Build option:
//   ACTIVITY_3_FULL_ADDER_OUTREG_EN
//     defined   -> sum/cout registered, one cycle latency, async reset to 0
//     undefined -> purely combinational, clk/rst unused (default)
// -----------------------------------------------------------------------------
module activity_3_full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    input  logic             clk,
    input  logic             rst
);

    // Reject illegal widths while elaborating rather than building a broken chain.
    generate
        if (!fa_width_ok(WIDTH)) begin : g_bad_width
            $error("activity_3_full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
        end
    endgenerate

    // k[i] is the carry into bit i; k[0] is the external carry-in.
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] sum_comb;

    assign k[0] = c;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_cell
            full_adder_cell u_cell (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (k[gi]),
                .s    (sum_comb[gi]),
                .cout (k[gi+1])
            );
        end
    endgenerate

`ifdef ACTIVITY_3_FULL_ADDER_OUTREG_EN
    logic             cout_reg;
    logic [WIDTH-1:0] sum_reg;

    // Reset wins over any edge and drops whatever result was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout_reg <= 1'b0;
            sum_reg  <= '0;
        end else begin
            cout_reg <= k[WIDTH];
            sum_reg  <= sum_comb;
        end
    end

    assign cout = cout_reg;
    assign sum  = sum_reg;
`else
    // clk and rst are deliberately unused here; folding them into a dead net
    // keeps them out of the datapath so a floating rst cannot disturb outputs.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign cout = k[WIDTH];
    assign sum  = sum_comb;
`endif

endmodule

// File: tb/tb_activity_3_full_adder.sv
// -----------------------------------------------------------------------------
// tb_activity_3_full_adder
// Self-checking bench for activity_3_full_adder at WIDTH = 1, 4, 8 and 16.
// Inputs change on the falling clock edge and outputs are sampled 1 ns after
// the rising edge, so the same sequences hold for both the combinational and
// the registered build. Registered-only reset behaviour is exercised when
// ACTIVITY_3_FULL_ADDER_OUTREG_EN is defined; otherwise the bench checks that
// rst has no effect on the combinational outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_activity_3_full_adder;

    logic clk;
    logic rst;

    logic        a1, b1, c1, cout1, sum1;
    logic [3:0]  a4, b4, sum4;
    logic        c4, cout4;
    logic [7:0]  a8, b8, sum8;
    logic        c8, cout8;
    logic [15:0] a16, b16, sum16;
    logic        c16, cout16;

    int tests_run;
    int tests_failed;

    activity_3_full_adder #(.WIDTH(1)) dut_w1 (
        .a(a1), .b(b1), .c(c1), .cout(cout1), .sum(sum1), .clk(clk), .rst(rst));
    activity_3_full_adder #(.WIDTH(4)) dut_w4 (
        .a(a4), .b(b4), .c(c4), .cout(cout4), .sum(sum4), .clk(clk), .rst(rst));
    activity_3_full_adder #(.WIDTH(8)) dut_w8 (
        .a(a8), .b(b8), .c(c8), .cout(cout8), .sum(sum8), .clk(clk), .rst(rst));
    activity_3_full_adder #(.WIDTH(16)) dut_w16 (
        .a(a16), .b(b16), .c(c16), .cout(cout16), .sum(sum16), .clk(clk), .rst(rst));

    // 20 ns period
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference: unsigned sum of the operands at width+1 bits.
    function automatic logic [64:0] ref_add(input int w, input logic [63:0] x,
                                            input logic [63:0] y, input logic ci);
        logic [64:0] mask;
        logic [64:0] total;
        mask  = (65'd1 << w) - 65'd1;
        total = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {64'd0, ci};
        return total & ((mask << 1) | 65'd1);
    endfunction

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Let a vector driven on the falling edge pass through one rising edge.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] truth_table [8];
    logic [64:0] exp_val;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        truth_table  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst = 1'b1;
        {a1, b1, c1} = '0;
        a4 = '0; b4 = '0; c4 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;
        a16 = '0; b16 = '0; c16 = 1'b0;

        #5;
`ifdef ACTIVITY_3_FULL_ADDER_OUTREG_EN
        // Outputs cleared by reset alone, before any rising edge.
        a4 = 4'd9; b4 = 4'd8;
        #1;
        check("w4_reset_no_edge", {64'd0, cout4, sum4}, 65'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=1 truth table, one vector per 20 ns cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {a1, b1, c1} = 3'(i);
            settle();
            check($sformatf("w1_tt_%0d", i), {63'd0, cout1, sum1}, {63'd0, truth_table[i]});
        end

        // WIDTH=8 directed boundary vectors.
        @(negedge clk); a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; settle();
        check("w8_ff_00_1", {56'd0, cout8, sum8}, {56'd0, 1'b1, 8'h00});
        @(negedge clk); a8 = 8'h5A; b8 = 8'h25; c8 = 1'b0; settle();
        check("w8_5a_25_0", {56'd0, cout8, sum8}, {56'd0, 1'b0, 8'h7F});
        @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; settle();
        check("w8_ff_ff_1", {56'd0, cout8, sum8}, {56'd0, 1'b1, 8'hFF});
        @(negedge clk); a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; settle();
        check("w8_00_00_0", {56'd0, cout8, sum8}, {56'd0, 1'b0, 8'h00});

        // WIDTH=4 directed vectors.
        @(negedge clk); a4 = 4'd9; b4 = 4'd8; c4 = 1'b0; settle();
        check("w4_9_8_0", {60'd0, cout4, sum4}, {60'd0, 1'b1, 4'd1});
        @(negedge clk); a4 = 4'd7; b4 = 4'd8; c4 = 1'b0; settle();
        check("w4_hold_f", {60'd0, cout4, sum4}, {60'd0, 1'b0, 4'hF});

`ifdef ACTIVITY_3_FULL_ADDER_OUTREG_EN
        // Mid-cycle reset while outputs hold 0xF: cleared before next edge,
        // then held inputs appear one edge after release.
        #2;
        a4 = 4'd3; b4 = 4'd4; c4 = 1'b1;
        #2;
        check("w4_inputs_between_edges", {60'd0, cout4, sum4}, {60'd0, 1'b0, 4'hF});
        rst = 1'b1;
        #1;
        check("w4_reset_mid_cycle", {60'd0, cout4, sum4}, 65'd0);
        settle();
        check("w4_reset_held_edge", {60'd0, cout4, sum4}, 65'd0);
        @(negedge clk);
        rst = 1'b0;
        settle();
        check("w4_after_release", {60'd0, cout4, sum4}, {60'd0, 1'b0, 4'd8});
`else
        // Combinational build: rst must not disturb the outputs.
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd4; c4 = 1'b1;
        rst = 1'b1;
        #1;
        check("w4_rst_ignored", {60'd0, cout4, sum4}, {60'd0, 1'b0, 4'd8});
        rst = 1'b0;
`endif

        // WIDTH=16 random vectors against the arithmetic reference.
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            exp_val = ref_add(16, {48'd0, a16}, {48'd0, b16}, c16);
            settle();
            check($sformatf("w16_rand_%0d", n), {48'd0, cout16, sum16}, exp_val);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/activity_3_full_adder.md
# activity_3_full_adder

Parameterizable ripple-carry full adder. It adds two operands `a` and `b` and a carry-in `c`, and produces `sum` and carry-out `cout`. The default instance is the single-bit full adder used in the arithmetic exercises. Wider instances serve as a small adder primitive in datapaths, with an optional registered output stage.

## Interface
- `WIDTH`, default 1: operand and sum width in bits; legal range 1..64.
- `clk`  input  1: rising-edge clock; used only when the output register is compiled in.
- `rst`  input  1: asynchronous, active-high reset; used only when the output register is compiled in.
- `a`  input  WIDTH: operand A, unsigned.
- `b`  input  WIDTH: operand B, unsigned.
- `c`  input  1: carry-in, weight 2^0.
- `cout`  output  1: carry-out, weight 2^WIDTH.
- `sum`  output  WIDTH: low WIDTH bits of a + b + c.
- Declaration order is fixed as `a, b, c, cout, sum, clk, rst`. Positional 5-port instantiation remains valid; `clk` and `rst` are then left unconnected.
- One clock; reset is asynchronous and active-high.

## Operation
- Arithmetic: {cout, sum} = a + b + c, evaluated at WIDTH+1 bits with no truncation of the carry.
- Bit i: sum[i] = a[i] ^ b[i] ^ k[i]; k[i+1] = a[i]&b[i] | a[i]&k[i] | b[i]&k[i]; k[0] = c; cout = k[WIDTH].
- The carry chain is a ripple through WIDTH cell instances. No lookahead.
- Boundaries:
  - All-ones a and b with c=1 gives sum all-ones and cout=1.
  - All-zero operands with c=0 gives sum 0 and cout 0.
  - WIDTH=1 reduces exactly to the 1-bit full-adder truth table.
- X/Z on any input bit propagates to the affected outputs. No X-masking logic.
- Combinational mode (default):
  - `clk` and `rst` are ignored.
  - Outputs follow inputs with pure gate delay and no state.
  - An unconnected `rst` must not corrupt the outputs.
- Registered mode:
  - `{cout, sum}` are captured into flops on each rising `clk`.
  - `rst`=1 asynchronously forces sum=0 and cout=0, regardless of clock.
  - Reset release lets the next rising edge capture the current inputs.
  - Reset asserted mid-operation discards the in-flight result. Nothing is replayed.

## Timing
- Combinational mode: zero cycles of latency. Outputs settle within the ripple delay, which is proportional to WIDTH. Zero-delay simulation is valid.
- Registered mode: one cycle of latency. Inputs sampled at edge N appear on outputs after edge N and hold until edge N+1.
- Registered mode reset values: sum = 0, cout = 0.
- No handshake. A new input set may be applied every cycle (registered) or at any time (combinational).
- Input changes between edges have no effect in registered mode.

## Configuration
- `ACTIVITY_3_FULL_ADDER_OUTREG_EN`:
  - Defined: `sum` and `cout` are registered as described above.
  - Undefined: purely combinational; no flops are inferred and `clk`/`rst` are unused.
- Default build leaves the macro undefined.

## Structure
- Package `full_adder_pkg` holds:
  - `FA_DEFAULT_WIDTH` = 1.
  - `FA_MAX_WIDTH` = 64.
  - The width-check function used for the elaboration-time assertion on `WIDTH`.
- Sub-module `full_adder_cell`:
  - Ports: a, b, cin → s, cout.
  - Pure combinational 1-bit full adder.
  - Instantiated WIDTH times by a generate loop that chains carries.
- The top level holds the generate loop, the optional output register, and the parameter assertion.

## Test plan
- WIDTH=1, combinational: apply the eight (a,b,c) combinations 000..111 at 20 ns spacing. Required {cout,sum}: 00, 01, 01, 10, 01, 10, 10, 11.
- WIDTH=8, combinational: a=0xFF, b=0x00, c=1 → sum=0x00, cout=1. Then a=0x5A, b=0x25, c=0 → sum=0x7F, cout=0.
- WIDTH=8, combinational: a=0xFF, b=0xFF, c=1 → sum=0xFF, cout=1. Then a=0, b=0, c=0 → sum=0x00, cout=0.
- WIDTH=4, registered:
  - Assert rst → sum=0, cout=0 immediately, with no clock edge.
  - Release rst, apply a=9, b=8, c=0 → after the next edge, sum=1, cout=1.
- WIDTH=4, registered: assert rst between edges while outputs hold 0xF → outputs drop to 0 before the next edge. Inputs held at a=3, b=4, c=1 appear as sum=8, cout=0 one edge after release.
- WIDTH=16, random: 1000 random (a,b,c) vectors compared against a (WIDTH+1)-bit reference sum in both modes.
